spike_rate_encoder: RTL

SPIKE_RATE_ENCODER -- requirements
Module: spike_rate_encoder

---
 rtl/snn_pkg.sv | 19 +
 rtl/lfsr16.sv | 24 ++
 rtl/spike_rate_encoder.sv | 109 ++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// Shared types and LFSR constants for the spiking front end.
// The LFSR step lives here so the generator and any predictor agree on one definition.
package snn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } enc_state_t;

    localparam int LFSR_WIDTH = 16;
    localparam logic [LFSR_WIDTH-1:0] LFSR_MASK = 16'hB400;

    // Right-shifting Galois form: the bit shifted out decides whether the taps are applied.
    function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR with synchronous seed load and step enable.
// Reset returns the register to its seed so a fresh presentation is reproducible.
module lfsr16
    import snn_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [LFSR_WIDTH-1:0] seed,
    input  logic                  en,
    output logic [LFSR_WIDTH-1:0] value
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= seed;
        end else if (load) begin
            value <= seed;
        end else if (en) begin
            value <= lfsr_step(value);
        end
    end

endmodule

// File: rtl/spike_rate_encoder.sv
// Rate-codes latched pixel intensities into per-channel spike trains over a fixed window.
// Each channel compares its pixel against the top bits of its own LFSR every timestep.
module spike_rate_encoder
    import snn_pkg::*;
#(
    parameter int              NUM_INPUTS  = 4,
    parameter int              PIXEL_WIDTH = 8,
    parameter int              WINDOW      = 100,
    parameter logic [15:0]     SEED        = 16'hACE1
)
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              stop,
    input  logic [NUM_INPUTS*PIXEL_WIDTH-1:0] pixel_in,
    output logic [NUM_INPUTS-1:0]             spike_out,
    output logic                              busy,
    output logic                              done,
    output logic [15:0]                       timestep
);

    localparam logic [15:0] LAST_TS = 16'(WINDOW - 1);

    enc_state_t              state;
    enc_state_t              state_next;
    logic [PIXEL_WIDTH-1:0]  pixel_reg [NUM_INPUTS];
    logic [LFSR_WIDTH-1:0]   lfsr_val  [NUM_INPUTS];
    logic [NUM_INPUTS-1:0]   spike_next;
    logic                    launch;
    logic                    advance;
    logic                    lfsr_en;

    // Saturated pixels always fire; otherwise fire when intensity beats the random draw.
    function automatic logic spike_bit(input logic [PIXEL_WIDTH-1:0] pix,
                                       input logic [LFSR_WIDTH-1:0]  lfsr);
        logic [PIXEL_WIDTH-1:0] rnd;
        rnd = lfsr[LFSR_WIDTH-1 -: PIXEL_WIDTH];
        return (&pix) || (pix > rnd);
    endfunction

    assign launch  = (state == IDLE) && start;
    assign advance = (state == RUN) && (state_next == RUN);
    assign lfsr_en = (state == RUN);
    assign busy    = (state == RUN);
    assign done    = (state == DONE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN: begin
                if (stop)                       state_next = IDLE;
                else if (timestep == LAST_TS)   state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The spike register is loaded one step ahead: on launch from the seeds, in RUN from the
    // value each LFSR is about to take, so spike_out lines up with the timestep shown.
    always_comb begin
        spike_next = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (launch) begin
                spike_next[i] = spike_bit(pixel_in[i*PIXEL_WIDTH +: PIXEL_WIDTH],
                                          16'(SEED + i));
            end else if (advance) begin
                spike_next[i] = spike_bit(pixel_reg[i], lfsr_step(lfsr_val[i]));
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            spike_out <= '0;
            timestep  <= '0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                pixel_reg[i] <= '0;
            end
        end else begin
            state     <= state_next;
            spike_out <= spike_next;
            if (launch) begin
                timestep <= '0;
                for (int i = 0; i < NUM_INPUTS; i++) begin
                    pixel_reg[i] <= pixel_in[i*PIXEL_WIDTH +: PIXEL_WIDTH];
                end
            end else if (advance) begin
                timestep <= timestep + 16'd1;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_lfsr
        localparam logic [LFSR_WIDTH-1:0] SEED_I = 16'(SEED + gi);
        lfsr16 u_lfsr (
            .clk   (clk),
            .rst   (rst),
            .load  (launch),
            .seed  (SEED_I),
            .en    (lfsr_en),
            .value (lfsr_val[gi])
        );
    end

endmodule
